// File: rtl/puf_capture_if.sv
// Control and readout bus of the PUF capture controller: capture request,
// voted results and the windowed display view.
interface puf_capture_if #(
  parameter int RSP_W = 64,
  parameter int CH_W  = 64,
  parameter int WIN_W = 16
);
  localparam int NWIN   = RSP_W / WIN_W;
  localparam int WSEL_W = (NWIN > 1) ? $clog2(NWIN) : 1;
  localparam int CNT_W  = $clog2(RSP_W + 1);

  logic              start;
  logic [CH_W-1:0]   chal_in;
  logic              busy;
  logic              done;
  logic [RSP_W-1:0]  rsp_stb;
  logic [RSP_W-1:0]  unstable;
  logic [CNT_W-1:0]  unstable_cnt;
  logic [WSEL_W-1:0] win_sel;
  logic [WIN_W-1:0]  rsp_win;

  modport master (
    output start, chal_in, win_sel,
    input  busy, done, rsp_stb, unstable, unstable_cnt, rsp_win
  );

  modport slave (
    input  start, chal_in, win_sel,
    output busy, done, rsp_stb, unstable, unstable_cnt, rsp_win
  );
endinterface

// File: rtl/puf_capture_ctrl.sv
// Repeated reset/settle/sample capture of a bistable-ring PUF bank with
// per-bit majority vote, instability mask/count and a display window.
module puf_capture_ctrl #(
  parameter int RSP_W      = 64,
  parameter int CH_W       = 64,
  parameter int SAMPLES    = 5,
  parameter int RST_CYC    = 4,
  parameter int SETTLE_CYC = 16,
  parameter int WIN_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  puf_capture_if.slave     bus,
  output logic [CH_W-1:0]  puf_chal_o,
  output logic             puf_rst_o,
  input  logic [RSP_W-1:0] puf_rsp_i
);
  localparam int UCW   = $clog2(RSP_W + 1);
  localparam int CMAX  = (RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC;
  localparam int CW    = $clog2(CMAX + 1);
  localparam int IW    = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RESET  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_VOTE   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             prst_q, prst_d;

  logic [RSP_W-1:0] sync1_q, sync2_q;
  logic [3:0]       ones_q [RSP_W];
  logic [RSP_W-1:0] first_q, mask_q;
  logic [CH_W-1:0]  chal_q;
  logic [RSP_W-1:0] rsp_q, unst_q;
  logic [UCW-1:0]   ucnt_q;
  logic [RSP_W-1:0] vote_s;

  function automatic logic [UCW-1:0] popcount(input logic [RSP_W-1:0] v);
    logic [UCW-1:0] c;
    c = '0;
    for (int i = 0; i < RSP_W; i++) begin
      c = c + UCW'(v[i]);
    end
    return c;
  endfunction

  // Sequencing: RESET and SETTLE are timed by cyc_q, SAMPLE repeats via idx_q.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RESET;
          cyc_d   = '0;
          idx_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RESET: begin
        if (cyc_q == CW'(RST_CYC - 1)) begin
          state_d = ST_SETTLE;
          cyc_d   = '0;
        end else begin
          cyc_d   = cyc_q + CW'(1);
        end
      end
      ST_SETTLE: begin
        if (cyc_q == CW'(SETTLE_CYC - 1)) begin
          state_d = ST_SAMPLE;
          cyc_d   = '0;
        end else begin
          cyc_d   = cyc_q + CW'(1);
        end
      end
      ST_SAMPLE: begin
        if (idx_q == IW'(SAMPLES - 1)) begin
          state_d = ST_VOTE;
        end else begin
          state_d = ST_RESET;
          idx_d   = idx_q + IW'(1);
        end
      end
      ST_VOTE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_VOTE);
    // Cells run only while settling and being sampled; held in reset otherwise.
    prst_d = !((state_d == ST_SETTLE) || (state_d == ST_SAMPLE));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      prst_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      prst_q  <= prst_d;
    end
  end

  always_comb begin
    vote_s = '0;
    for (int i = 0; i < RSP_W; i++) begin
      vote_s[i] = (ones_q[i] > 4'(SAMPLES / 2));
    end
  end

  // Synchroniser, per-bit accumulation and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      first_q <= '0;
      mask_q  <= '0;
      chal_q  <= '0;
      rsp_q   <= '0;
      unst_q  <= '0;
      ucnt_q  <= '0;
      for (int i = 0; i < RSP_W; i++) begin
        ones_q[i] <= 4'd0;
      end
    end else begin
      sync1_q <= puf_rsp_i;
      sync2_q <= sync1_q;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            chal_q  <= bus.chal_in;
            first_q <= '0;
            mask_q  <= '0;
            for (int i = 0; i < RSP_W; i++) begin
              ones_q[i] <= 4'd0;
            end
          end
        end
        ST_SAMPLE: begin
          for (int i = 0; i < RSP_W; i++) begin
            ones_q[i] <= ones_q[i] + {3'b000, sync2_q[i]};
          end
          if (idx_q == '0) begin
            first_q <= sync2_q;
          end else begin
            mask_q  <= mask_q | (sync2_q ^ first_q);
          end
        end
        ST_VOTE: begin
          rsp_q  <= vote_s;
          unst_q <= mask_q;
          ucnt_q <= popcount(mask_q);
        end
        default: begin
        end
      endcase
    end
  end

  assign puf_chal_o       = chal_q;
  assign puf_rst_o        = prst_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.rsp_stb      = rsp_q;
  assign bus.unstable     = unst_q;
  assign bus.unstable_cnt = ucnt_q;
  assign bus.rsp_win      = rsp_q[bus.win_sel * WIN_W +: WIN_W];
endmodule

// File: tb/tb_puf_capture_ctrl.sv
// Randomised scoreboard bench for puf_capture_ctrl: expected capture results
// are queued at start acceptance and checked when done pulses.
module tb_puf_capture_ctrl;
  localparam int RSP_W = 64;
  localparam int CH_W  = 64;
  localparam int WIN_W = 16;
  localparam int NS    = 5;
  localparam int R     = 4;
  localparam int S     = 16;
  localparam int P     = R + S + 1;
  localparam int L     = NS * P + 1;

  typedef struct {
    logic [RSP_W-1:0] rsp;
    logic [RSP_W-1:0] unst;
    int               cnt;
    int               edge_n;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [CH_W-1:0]  puf_chal;
  logic             puf_rst;
  logic [RSP_W-1:0] puf_rsp;

  int               checks = 0;
  int               failures = 0;
  int               edge_cnt = 0;
  exp_t             exp_q[$];
  exp_t             mon_e;
  logic [RSP_W-1:0] model_stb;
  logic [RSP_W-1:0] samp_v [NS];
  logic [4:0]       b0_pat;
  logic [4:0]       b63_pat;

  puf_capture_if #(.RSP_W(RSP_W), .CH_W(CH_W), .WIN_W(WIN_W)) bus ();

  puf_capture_ctrl #(
    .RSP_W(RSP_W), .CH_W(CH_W), .SAMPLES(NS),
    .RST_CYC(R), .SETTLE_CYC(S), .WIN_W(WIN_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .puf_chal_o(puf_chal),
    .puf_rst_o (puf_rst),
    .puf_rsp_i (puf_rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Majority and disagreement straight from the sample set.
  function automatic exp_t model_capture();
    exp_t e;
    int   ones;
    e.rsp  = '0;
    e.unst = '0;
    for (int b = 0; b < RSP_W; b++) begin
      ones = 0;
      for (int k = 0; k < NS; k++) ones += int'(samp_v[k][b]);
      e.rsp[b]  = (2 * ones > NS);
      e.unst[b] = (ones != 0) && (ones != NS);
    end
    e.cnt    = $countones(e.unst);
    e.edge_n = 0;
    return e;
  endfunction

  task automatic new_samples();
    logic [63:0] base;
    base = rnd64();
    for (int k = 0; k < NS; k++) samp_v[k] = base ^ (rnd64() & rnd64() & rnd64());
  endtask

  task automatic capture(input logic [CH_W-1:0] ch, input bit toggle, input int pulse_at,
                         input int abort_at, input bit chain);
    exp_t e;
    int   m;
    e = model_capture();
    bus.start   = 1'b1;
    bus.chal_in = ch;
    puf_rsp     = rnd64();
    @(posedge clk); #1;
    e.edge_n = edge_cnt + L;
    exp_q.push_back(e);
    bus.start = 1'b0;
    for (int n = 0; n < L; n++) begin
      chk("busy_run", 64'(bus.busy), 64'd1);
      if (n < NS * P) chk("puf_rst_seq", 64'(puf_rst), 64'((n % P) < R));
      chk("rsp_hold", bus.rsp_stb, model_stb);
      chk("puf_chal", puf_chal, ch);
      if (n == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_puf_rst", 64'(puf_rst), 64'd1);
        chk("abort_rsp_stb", bus.rsp_stb, 64'd0);
        chk("abort_unstable", bus.unstable, 64'd0);
        chk("abort_cnt", 64'(bus.unstable_cnt), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        e = exp_q.pop_back();
        model_stb = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        return;
      end
      bus.start = (n == pulse_at) || (chain && (n == L - 1));
      if (n == pulse_at) bus.chal_in = rnd64();
      m = n + 1;
      if ((m % P) == P - 2) puf_rsp = samp_v[m / P];
      else if (toggle)      puf_rsp = rnd64();
      else                  puf_rsp = samp_v[(m / P < NS) ? m / P : NS - 1];
      @(posedge clk); #1;
    end
    chk("busy_after_done", 64'(bus.busy), 64'd0);
    model_stb = e.rsp;
  endtask

  // Scoreboard monitor: every done pulse must match the oldest queued capture.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no pending capture (t=%0t)", $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_stb", bus.rsp_stb, mon_e.rsp);
        chk("unstable", bus.unstable, mon_e.unst);
        chk("unstable_cnt", 64'(bus.unstable_cnt), 64'(mon_e.cnt));
        chk("done_edge", 64'(edge_cnt), 64'(mon_e.edge_n));
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.chal_in = '0;
    bus.win_sel = '0;
    puf_rsp     = '0;
    model_stb   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_puf_rst", 64'(puf_rst), 64'd1);
    chk("rst_puf_chal", puf_chal, 64'd0);
    chk("rst_rsp_stb", bus.rsp_stb, 64'd0);
    chk("rst_unstable", bus.unstable, 64'd0);
    chk("rst_cnt", 64'(bus.unstable_cnt), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_puf_rst", 64'(puf_rst), 64'd1);

    for (int k = 0; k < NS; k++) samp_v[k] = 64'h0123_4567_89AB_CDEF;
    capture(64'hA5A5_5A5A_0F0F_F0F0, 1'b0, -1, -1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    for (int ws = 0; ws < RSP_W / WIN_W; ws++) begin
      bus.win_sel = 2'(ws);
      #1;
      chk("rsp_win", 64'(bus.rsp_win), (model_stb >> (ws * WIN_W)) & 64'h0000_0000_0000_FFFF);
    end
    @(posedge clk); #1;

    b0_pat  = 5'b01011;
    b63_pat = 5'b00100;
    for (int k = 0; k < NS; k++) begin
      samp_v[k]     = 64'h0123_4567_89AB_CDEF;
      samp_v[k][0]  = b0_pat[k];
      samp_v[k][63] = b63_pat[k];
    end
    capture(rnd64(), 1'b1, -1, -1, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    new_samples();
    capture(rnd64(), 1'b1, 50, -1, 1'b1);
    new_samples();
    capture(rnd64(), 1'b1, -1, -1, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    new_samples();
    capture(rnd64(), 1'b1, -1, 2 * P + R + 5, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    new_samples();
    capture(rnd64(), 1'b1, -1, -1, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    for (int k = 0; k < NS; k++) samp_v[k] = 64'hFFFF_FFFF_FFFF_FFFF;
    capture(rnd64(), 1'b1, -1, -1, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    for (int t = 0; t < 6; t++) begin
      new_samples();
      capture(rnd64(), 1'($urandom_range(1)), -1, -1, 1'b0);
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
